fifo_apb_master: RTL and testbench

- Single-clock command executor that sits directly downstream of the read port of the bridge's clock-crossing command FIFO, in the APB clock domain.
- Pops one 64-bit command word at a time, runs exactly one APB3 transfer, and pushes a 64-bit response word into the response FIFO going back toward the ICB side.
- Guards against hung slaves with a PREADY timeout.

---
 rtl/fifo_apb_master.sv | 104 ++++++++++
 tb/tb_fifo_apb_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_apb_master.sv
// Command-FIFO driven APB3 master: pops one 64-bit command, runs one APB
// transfer (with PREADY timeout), pushes one 64-bit response.
module fifo_apb_master #(
  parameter int TIMEOUT   = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fifo_empty,
  output logic                 fifo_rdata_en,
  input  logic [63:0]          fifo_rdata,
  input  logic                 resp_full,
  output logic [63:0]          resp_wdata,
  output logic                 resp_wdata_vld,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [31:0]          paddr,
  output logic [31:0]          pwdata,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, SETUP, ACCESS, RESP} state_t;

  localparam logic [7:0]           TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [31:0] rdata_q;
  logic        slverr_q;
  logic        tmo_q;

  // Command bit 1 is reserved and deliberately dropped.
  logic unused_rsvd;
  assign unused_rsvd = fifo_rdata[1];

  assign fifo_rdata_en  = (state == IDLE) && !fifo_empty;
  assign resp_wdata_vld = (state == RESP) && !resp_full;
  assign busy           = (state != IDLE);
  assign resp_wdata     = {rdata_q, 30'd0, tmo_q, slverr_q};

  // psel/penable are set one edge early so they are registered when the
  // FSM sits in SETUP/ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      tmo_cnt  <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      tmo_q    <= 1'b0;
      err_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (fifo_rdata_en) state <= LOAD;
        LOAD: begin
          paddr  <= {fifo_rdata[31:2], 2'b00};
          pwdata <= fifo_rdata[63:32];
          pwrite <= fifo_rdata[0];
          psel   <= 1'b1;
          state  <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          tmo_cnt <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          if (pready) begin
            rdata_q  <= pwrite ? 32'd0 : prdata;
            slverr_q <= pslverr;
            tmo_q    <= 1'b0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            state    <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            rdata_q  <= '0;
            slverr_q <= 1'b0;
            tmo_q    <= 1'b1;
            psel     <= 1'b0;
            penable  <= 1'b0;
            state    <= RESP;
          end
        end
        RESP: if (!resp_full) begin
          state <= IDLE;
          if ((slverr_q || tmo_q) && (err_cnt != '1)) err_cnt <= err_cnt + ERR_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_apb_master.sv
// Directed bench for fifo_apb_master: FIFO/slave models, a per-cycle
// transaction-level scoreboard, and literal expectations per scenario.
module tb_fifo_apb_master;
  localparam int TIMEOUT = 16;
  localparam int ECW     = 3;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           fifo_empty = 1'b1, fifo_rdata_en;
  logic [63:0]    fifo_rdata = '0;
  logic           resp_full = 1'b0;
  logic [63:0]    resp_wdata;
  logic           resp_wdata_vld;
  logic           psel, penable, pwrite;
  logic [31:0]    paddr, pwdata;
  logic [31:0]    prdata = '0;
  logic           pready = 1'b0, pslverr = 1'b0;
  logic           busy;
  logic [ECW-1:0] err_cnt;

  int checks = 0, failures = 0, cyc = 0;
  int n_pushed = 0, n_resp = 0, rd_ptr = 0;

  logic [63:0] c_cmd [64];
  int          c_w   [64];
  logic [31:0] c_rd  [64];
  logic        c_err [64];
  int          setup_cyc [64];

  fifo_apb_master #(.TIMEOUT(TIMEOUT), .ERR_CNT_W(ECW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rdata_en(fifo_rdata_en),
    .fifo_rdata(fifo_rdata), .resp_full(resp_full), .resp_wdata(resp_wdata),
    .resp_wdata_vld(resp_wdata_vld), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [63:0] c, input int w, input logic [31:0] rd, input logic e);
    c_cmd[n_pushed] = c; c_w[n_pushed] = w; c_rd[n_pushed] = rd; c_err[n_pushed] = e;
    n_pushed++;
  endtask

  // Expected response from the command's fate: timed out, or completed.
  function automatic logic [63:0] exp_resp(input int i);
    if (c_w[i] >= TIMEOUT) return 64'h2;
    return {(c_cmd[i][0] ? 32'h0 : c_rd[i]), 30'h0, 1'b0, c_err[i]};
  endfunction

  function automatic int exp_access(input int i);
    return (c_w[i] >= TIMEOUT) ? TIMEOUT : c_w[i] + 1;
  endfunction

  // Command FIFO: registered read data, 0 when not popped.
  initial begin : fifo_model
    bit pop;
    forever begin
      @(negedge clk);
      pop = rst_n && fifo_rdata_en;
      @(posedge clk); #1;
      if (!rst_n) begin
        rd_ptr = n_pushed;
        fifo_rdata = '0;
      end else if (pop) begin
        fifo_rdata = c_cmd[rd_ptr];
        rd_ptr++;
      end else fifo_rdata = '0;
      fifo_empty = (rd_ptr == n_pushed);
    end
  end

  // APB slave + scoreboard, evaluated once per cycle on the falling edge.
  initial begin : cmp
    int sidx, ridx, cur, acc;
    bit in_acc;
    logic [ECW-1:0] m_err;
    sidx = 0; ridx = 0; cur = 0; acc = 0; in_acc = 0; m_err = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sidx = n_pushed; ridx = n_pushed; acc = 0; in_acc = 0; m_err = '0;
        pready = 1'b0; pslverr = 1'b0;
        continue;
      end
      chk("penable_needs_psel", {63'd0, penable & ~psel}, 64'd0);
      chk("pop_only_when_idle", {63'd0, fifo_rdata_en & busy}, 64'd0);
      if (psel && !penable) begin
        chk("setup_has_cmd", {63'd0, sidx < n_pushed}, 64'd1);
        cur = sidx; setup_cyc[sidx] = cyc; sidx++; acc = 0;
      end
      if (psel && cur < n_pushed) begin
        chk("paddr", paddr, {c_cmd[cur][31:2], 2'b00});
        chk("pwdata", pwdata, c_cmd[cur][63:32]);
        chk("pwrite", pwrite, c_cmd[cur][0]);
      end
      if (psel && penable) begin
        pready  = (acc >= c_w[cur]);
        pslverr = pready && c_err[cur];
        prdata  = pready ? c_rd[cur] : (32'hBAD0_0000 | acc);
        acc++; in_acc = 1;
      end else begin
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hBADD_CAFE;
        if (in_acc && !psel) begin
          chk("access_cycles", acc, exp_access(cur));
          in_acc = 0;
        end
      end
      chk("err_cnt", err_cnt, m_err);
      if (resp_wdata_vld) begin
        n_resp++;
        chk("resp_has_cmd", {63'd0, ridx < n_pushed}, 64'd1);
        if (ridx < n_pushed) begin
          chk("resp_word", resp_wdata, exp_resp(ridx));
          if ((c_w[ridx] >= TIMEOUT || c_err[ridx]) && m_err != '1) m_err++;
          ridx++;
        end
      end
      if (psel || resp_wdata_vld) chk("busy_in_xfer", busy, 1);
    end
  end

  task automatic observe(output int np, output int ne, output logic [31:0] a,
                         output logic [31:0] d, output logic w);
    int t;
    np = 0; ne = 0; a = '0; d = '0; w = 1'b0; t = 0;
    while (!psel && t < 300) begin @(negedge clk); t++; end
    chk("wait_psel", psel, 1);
    a = paddr; d = pwdata; w = pwrite;
    while (psel && t < 600) begin
      np++;
      if (penable) ne++;
      @(negedge clk); t++;
    end
  endtask

  task automatic wait_push(output logic [63:0] w);
    int t;
    t = 0;
    while (!resp_wdata_vld && t < 300) begin @(negedge clk); t++; end
    chk("wait_push", resp_wdata_vld, 1);
    w = resp_wdata;
    @(negedge clk);
  endtask

  task automatic wait_resp(input int target);
    int t;
    t = 0;
    while (n_resp < target && t < 400) begin @(negedge clk); t++; end
    chk("resp_count", n_resp, target);
    @(negedge clk);
  endtask

  initial begin : main
    logic [63:0] w;
    logic [31:0] a, d;
    logic wr;
    int np, ne, base, tgt, nr;

    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_resp_wdata", resp_wdata, 0);
    chk("rst_resp_vld", resp_wdata_vld, 0);
    chk("rst_pop", fifo_rdata_en, 0);
    chk("rst_paddr", paddr, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // zero-wait write
    push(64'h1234_5678_0000_0101, 0, 32'h0, 1'b0);
    observe(np, ne, a, d, wr);
    chk("wr_psel_cycles", np, 2);
    chk("wr_penable_cycles", ne, 1);
    chk("wr_paddr", a, 32'h100);
    chk("wr_pwdata", d, 32'h1234_5678);
    chk("wr_pwrite", wr, 1);
    wait_push(w);
    chk("wr_resp", w, 64'h0);

    // read, 3 wait states
    push(64'h0000_0000_0000_0200, 3, 32'hCAFE_F00D, 1'b0);
    observe(np, ne, a, d, wr);
    chk("rd_psel_cycles", np, 5);
    chk("rd_access_cycles", ne, 4);
    chk("rd_pwrite", wr, 0);
    wait_push(w);
    chk("rd_resp", w, 64'hCAFE_F00D_0000_0000);
    chk("rd_err_cnt", err_cnt, 0);

    // timeout, then pready exactly on the last allowed cycle
    push(64'h0000_0000_0000_0300, 255, 32'h7777_7777, 1'b0);
    observe(np, ne, a, d, wr);
    chk("tmo_access_cycles", ne, 16);
    chk("tmo_psel_cycles", np, 17);
    wait_push(w);
    chk("tmo_resp", w, 64'h2);
    chk("tmo_err_cnt", err_cnt, 1);
    push(64'h0000_0000_0000_0304, 15, 32'h1111_2222, 1'b0);
    observe(np, ne, a, d, wr);
    chk("edge_access_cycles", ne, 16);
    wait_push(w);
    chk("edge_resp", w, 64'h1111_2222_0000_0000);
    chk("edge_err_cnt", err_cnt, 1);

    // slave error on a write; reserved bit 1 set
    push(64'hAAAA_5555_0000_0407, 1, 32'h0, 1'b1);
    observe(np, ne, a, d, wr);
    chk("err_paddr", a, 32'h404);
    chk("err_pwdata", d, 32'hAAAA_5555);
    chk("err_pwrite", wr, 1);
    wait_push(w);
    chk("err_resp", w, 64'h1);
    chk("err_err_cnt", err_cnt, 2);

    // response backpressure with a second command queued
    resp_full = 1'b1;
    push(64'h0000_0000_0000_0500, 0, 32'h0BAD_F00D, 1'b0);
    push(64'h0000_0001_0000_0505, 0, 32'h0, 1'b0);
    observe(np, ne, a, d, wr);
    w = resp_wdata;
    chk("bp_word", w, 64'h0BAD_F00D_0000_0000);
    for (int i = 0; i < 10; i++) begin
      chk("bp_no_push", resp_wdata_vld, 0);
      chk("bp_stable", resp_wdata, w);
      chk("bp_no_pop", fifo_rdata_en, 0);
      @(posedge clk); #1;
      if (i == 9) resp_full = 1'b0;
      @(negedge clk);
    end
    chk("bp_push_first", resp_wdata_vld, 1);
    wait_push(w);
    observe(np, ne, a, d, wr);
    chk("bp2_paddr", a, 32'h504);
    wait_push(w);
    chk("bp2_resp", w, 64'h0);

    // back-to-back
    base = n_pushed;
    tgt = n_resp + 8;
    for (int k = 0; k < 8; k++)
      push({32'h100 + k, 32'h1000 + 32'(k * 4) + 32'(k & 1)}, 0, 32'hA000_0000 + k, 1'b0);
    wait_resp(tgt);
    chk("b2b_idle_after", busy, 0);
    for (int k = 1; k < 8; k++)
      chk("b2b_spacing", setup_cyc[base + k] - setup_cyc[base + k - 1], 5);

    // error counter saturation
    tgt = n_resp + 8;
    for (int k = 0; k < 8; k++) push(64'h0000_0000_0000_0801, 0, 32'h0, 1'b1);
    wait_resp(tgt);
    chk("sat_err_cnt", err_cnt, 3'd7);

    // reset in the middle of ACCESS
    push(64'h0000_0000_0000_0600, 255, 32'h0, 1'b0);
    np = 0;
    while (!(psel && penable) && np < 300) begin @(negedge clk); np++; end
    chk("wait_access", {63'd0, psel & penable}, 64'd1);
    @(negedge clk);
    nr = n_resp;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_psel", psel, 0);
    chk("arst_penable", penable, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err_cnt", err_cnt, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("arst_no_resp", n_resp, nr);
    chk("arst_idle", busy, 0);
    push(64'h0000_0000_0000_0700, 0, 32'h1357_9BDF, 1'b0);
    observe(np, ne, a, d, wr);
    wait_push(w);
    chk("post_rst_resp", w, 64'h1357_9BDF_0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
